// File: rtl/key_param_loader.sv
// key_param_loader: assembles a WW*NWORDS-bit modulus from host words, starts the precompute
// engine, and latches n0'/r/t/n into stable output registers. Macro KEY_PARAM_TIMEOUT_EN adds a WAIT watchdog.
module key_param_loader #(
   parameter int WW             = 32,
   parameter int NWORDS         = 32,
   parameter int DONE_GUARD     = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   localparam int NBITS         = WW * NWORDS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WW-1:0]    in_word,
   output logic             eng_start,
   output logic [NBITS-1:0] eng_n,
   input  logic             eng_done,
   input  logic [31:0]      eng_n0p,
   input  logic [NBITS-1:0] eng_r,
   input  logic [NBITS-1:0] eng_t,
   output logic             params_valid,
   output logic [31:0]      n0p_out,
   output logic [NBITS-1:0] r_out,
   output logic [NBITS-1:0] t_out,
   output logic [NBITS-1:0] n_out,
   output logic             busy,
   output logic             error
);
   localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int GW = (DONE_GUARD > 0) ? $clog2(DONE_GUARD + 1) : 1;
   localparam logic [CW-1:0] LAST_IDX   = CW'(NWORDS - 1);
   localparam logic [GW-1:0] GUARD_INIT = GW'(DONE_GUARD);

   if (NWORDS < 2 || DONE_GUARD < 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8192) begin : g_param_check
      $error("key_param_loader: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_START, S_WAIT, S_HOLD
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [GW-1:0]    r_guard;
   logic [WW-1:0]    r_word [NWORDS];
   logic             r_eng_start;
   logic             r_params_valid;
   logic             r_error;
   logic [31:0]      r_n0p;
   logic [NBITS-1:0] r_r;
   logic [NBITS-1:0] r_t;
   logic [NBITS-1:0] r_n;

   logic             w_xfer;
   logic             w_wr_en;
   logic [CW-1:0]    w_wr_idx;
   logic             w_new_load;
   logic             w_chk_fail;
   logic             w_latch;
   logic             w_timeout;
   logic             w_is_one;

`ifdef KEY_PARAM_TIMEOUT_EN
   localparam logic [12:0] WDOG_LAST = 13'(TIMEOUT_CYCLES - 1);
   logic [12:0] r_wdog;
`endif

   for (genvar gi = 0; gi < NWORDS; gi++) begin : g_pack
      assign eng_n[gi*WW +: WW] = r_word[gi];
   end

   assign in_ready     = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_HOLD);
   assign busy         = (r_state == S_LOAD) || (r_state == S_START) || (r_state == S_WAIT);
   assign w_xfer       = in_valid && in_ready;
   assign w_is_one     = (eng_n == NBITS'(1));
   assign eng_start    = r_eng_start;
   assign params_valid = r_params_valid;
   assign error        = r_error;
   assign n0p_out      = r_n0p;
   assign r_out        = r_r;
   assign t_out        = r_t;
   assign n_out        = r_n;

   always_comb begin
      w_state_next = r_state;
      w_wr_en      = 1'b0;
      w_wr_idx     = '0;
      w_new_load   = 1'b0;
      w_chk_fail   = 1'b0;
      w_latch      = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE, S_HOLD: begin
            if (w_xfer) begin
               w_wr_en      = 1'b1;
               w_new_load   = 1'b1;
               w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_xfer) begin
               w_wr_en  = 1'b1;
               w_wr_idx = r_cnt;
               if (r_cnt == LAST_IDX) begin
                  w_state_next = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            // An even modulus or n==1 has no Montgomery inverse; refuse to start the engine.
            if (!eng_n[0] || w_is_one) begin
               w_chk_fail   = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            // The engine's done is sticky, so a stale level from the previous run is masked by the guard.
            if (r_guard == '0 && eng_done) begin
               w_latch      = 1'b1;
               w_state_next = S_HOLD;
            end
`ifdef KEY_PARAM_TIMEOUT_EN
            else if (r_wdog == WDOG_LAST) begin
               w_timeout    = 1'b1;
               w_state_next = S_IDLE;
            end
`endif
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_guard        <= '0;
         r_eng_start    <= 1'b0;
         r_params_valid <= 1'b0;
         r_error        <= 1'b0;
         r_n0p          <= '0;
         r_r            <= '0;
         r_t            <= '0;
         r_n            <= '0;
      end else begin
         r_state     <= w_state_next;
         r_eng_start <= (w_state_next == S_START);
         if (w_wr_en) begin
            r_cnt <= w_wr_idx + CW'(1);
         end
         if (r_state == S_START) begin
            r_guard <= GUARD_INIT;
         end else if (r_state == S_WAIT && r_guard != '0) begin
            r_guard <= r_guard - GW'(1);
         end
         if (w_chk_fail || w_timeout) begin
            r_error <= 1'b1;
         end else if (w_new_load) begin
            r_error <= 1'b0;
         end
         if (w_latch) begin
            r_params_valid <= 1'b1;
            r_n0p          <= eng_n0p;
            r_r            <= eng_r;
            r_t            <= eng_t;
            r_n            <= eng_n;
         end else if (w_new_load) begin
            r_params_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NWORDS; i++) begin
         if (rst) begin
            r_word[i] <= '0;
         end else if (w_wr_en && (w_wr_idx == CW'(i))) begin
            r_word[i] <= in_word;
         end
      end
   end

`ifdef KEY_PARAM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst || r_state != S_WAIT) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= r_wdog + 13'd1;
      end
   end
`endif

endmodule

// File: tb/tb_key_param_loader.sv
// Scoreboard bench for key_param_loader: stimulus pushes expected start pulses and latched
// parameter sets; a negedge monitor pops and compares them when the DUT presents them.
module tb_key_param_loader;
   localparam int WW     = 32;
   localparam int NWORDS = 32;
   localparam int NBITS  = WW * NWORDS;
`ifdef KEY_PARAM_TIMEOUT_EN
   localparam int TO_CYC = 64;
`else
   localparam int TO_CYC = 4096;
`endif
   localparam int MODE_DELAY  = 0;
   localparam int MODE_STICKY = 1;
   localparam int MODE_NEVER  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WW-1:0]    in_word;
   logic             eng_start;
   logic [NBITS-1:0] eng_n;
   logic             eng_done;
   logic [31:0]      eng_n0p;
   logic [NBITS-1:0] eng_r;
   logic [NBITS-1:0] eng_t;
   logic             params_valid;
   logic [31:0]      n0p_out;
   logic [NBITS-1:0] r_out;
   logic [NBITS-1:0] t_out;
   logic [NBITS-1:0] n_out;
   logic             busy;
   logic             error;

   key_param_loader #(
      .WW(WW), .NWORDS(NWORDS), .DONE_GUARD(2), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .eng_start(eng_start), .eng_n(eng_n), .eng_done(eng_done), .eng_n0p(eng_n0p),
      .eng_r(eng_r), .eng_t(eng_t), .params_valid(params_valid), .n0p_out(n0p_out),
      .r_out(r_out), .t_out(t_out), .n_out(n_out), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cyc;
      logic [NBITS-1:0] n;
   } start_exp_t;

   typedef struct {
      int               cyc;
      logic [31:0]      n0p;
      logic [NBITS-1:0] r;
      logic [NBITS-1:0] t;
      logic [NBITS-1:0] n;
   } res_exp_t;

   start_exp_t start_q[$];
   res_exp_t   res_q[$];

   int checks      = 0;
   int failures    = 0;
   int cyc         = 0;
   int start_count = 0;
   int mode        = MODE_DELAY;
   int dcnt        = 0;
   int last_cyc    = 0;
   logic [WW-1:0] words [NWORDS];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_wide(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         for (int i = 0; i < NWORDS; i++) begin
            if (act[i*WW +: WW] !== exp[i*WW +: WW]) begin
               $display("FAIL %s: word %0d got 0x%08h expected 0x%08h (cycle %0d)",
                        name, i, act[i*WW +: WW], exp[i*WW +: WW], cyc);
               break;
            end
         end
      end
   endtask

   function automatic logic [NBITS-1:0] build_n();
      logic [NBITS-1:0] v;
      for (int i = 0; i < NWORDS; i++) v[i*WW +: WW] = words[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends words[first..last] back to back; the caller is aligned just after a posedge.
   task automatic send_range(input int first, input int last);
      for (int k = first; k <= last; k++) begin
         in_valid = 1'b1;
         in_word  = words[k];
         @(negedge clk);
         chk("in_ready_load", 64'(in_ready), 64'(1));
         tick();
         if (k == 0) begin
            chk("error_clear_first_word", 64'(error), 64'(0));
            chk("pv_drop_first_word", 64'(params_valid), 64'(0));
         end
      end
      in_valid = 1'b0;
      last_cyc = cyc;
   endtask

   task automatic wait_pv();
      int n;
      n = 0;
      while (!params_valid && n < 40) begin
         tick();
         n++;
      end
      chk("params_valid_within_bound", 64'(params_valid), 64'(1));
   endtask

   // Engine model: done is a sticky level, raised 10 cycles after start in DELAY mode.
   initial begin
      eng_done = 1'b0;
      forever begin
         @(negedge clk);
         if (eng_start) begin
            if (mode != MODE_STICKY) eng_done = 1'b0;
            dcnt = (mode == MODE_DELAY) ? 10 : 0;
         end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) eng_done = 1'b1;
         end
      end
   end

   // Monitor: compares every start pulse and every params_valid rise against the queues.
   initial begin
      start_exp_t se;
      res_exp_t   re;
      logic       pv_prev;
      pv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (eng_start) begin
            start_count++;
            if (start_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_start: eng_start=1 at cycle %0d, required 0", cyc);
            end else begin
               se = start_q.pop_front();
               chk("start_cycle", 64'(cyc), 64'(se.cyc));
               chk_wide("eng_n_at_start", eng_n, se.n);
            end
         end
         if (params_valid && !pv_prev) begin
            if (res_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_params_valid: rose at cycle %0d, required no rise", cyc);
            end else begin
               re = res_q.pop_front();
               chk("pv_rise_cycle", 64'(cyc), 64'(re.cyc));
               chk("n0p_out", 64'(n0p_out), 64'(re.n0p));
               chk_wide("r_out", r_out, re.r);
               chk_wide("t_out", t_out, re.t);
               chk_wide("n_out", n_out, re.n);
            end
         end
         pv_prev = params_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: bench did not finish, required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0]      a_n0p;
      logic [NBITS-1:0] a_r, a_t, a_n, c_n;
      int               p;

      rst = 1'b1; in_valid = 1'b0; in_word = '0;
      eng_n0p = '0; eng_r = '0; eng_t = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_params_valid", 64'(params_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_error", 64'(error), 64'(0));
      chk("rst_eng_start", 64'(eng_start), 64'(0));
      chk("rst_in_ready_idle", 64'(in_ready), 64'(1));
      chk("rst_n0p_out", 64'(n0p_out), 64'(0));
      chk_wide("rst_r_out", r_out, '0);
      chk_wide("rst_n_out", n_out, '0);
      chk_wide("rst_eng_n", eng_n, '0);

      // Load A, done 10 cycles after start
      tick();
      words[0] = 32'h0000_0001;
      for (int k = 1; k < NWORDS - 1; k++) words[k] = {8{4'(k)}};
      words[NWORDS-1] = 32'h8000_0000;
      a_n0p = 32'hA1A1_0001; a_r = {NWORDS{32'h0000_00A2}}; a_t = {NWORDS{32'h0000_00A3}};
      eng_n0p = a_n0p; eng_r = a_r; eng_t = a_t; mode = MODE_DELAY;
      a_n = build_n();
      send_range(0, NWORDS - 1);
      p = last_cyc;
      start_q.push_back('{p + 1, a_n});
      res_q.push_back('{p + 12, a_n0p, a_r, a_t, a_n});
      wait_pv();
      chk("hold_busy", 64'(busy), 64'(0));
      chk("hold_in_ready", 64'(in_ready), 64'(1));
      chk_wide("hold_eng_n", eng_n, a_n);

      // Reload from HOLD with done held high: guard must mask it until START+3
      for (int k = 0; k < NWORDS; k++) words[k] = 32'(k) * 32'h0001_0003 + 32'h1;
      eng_n0p = 32'hB2B2_0002; eng_r = {NWORDS{32'h0000_00B2}}; eng_t = {NWORDS{32'h0000_00B3}};
      mode = MODE_STICKY;
      send_range(0, 0);
      chk("old_n0p_after_new_word0", 64'(n0p_out), 64'(a_n0p));
      chk_wide("old_r_after_new_word0", r_out, a_r);
      chk_wide("old_n_after_new_word0", n_out, a_n);
      send_range(1, NWORDS - 1);
      p = last_cyc;
      start_q.push_back('{p + 1, build_n()});
      res_q.push_back('{p + 5, 32'hB2B2_0002, {NWORDS{32'h0000_00B2}}, {NWORDS{32'h0000_00B3}}, build_n()});
      repeat (4) tick();
      chk("no_latch_before_guard_n0p", 64'(n0p_out), 64'(a_n0p));
      chk("wait_busy", 64'(busy), 64'(1));
      wait_pv();

      // Even modulus: error, no start, back in IDLE
      words[0] = 32'h0000_0002;
      send_range(0, NWORDS - 1);
      tick();
      chk("even_error", 64'(error), 64'(1));
      chk("even_in_ready_idle", 64'(in_ready), 64'(1));
      chk("even_busy", 64'(busy), 64'(0));
      chk("even_params_valid", 64'(params_valid), 64'(0));
      chk("even_n0p_kept", 64'(n0p_out), 64'(32'hB2B2_0002));
      repeat (4) tick();

      // Modulus == 1: error; first word of this load must clear the previous error
      words[0] = 32'h0000_0001;
      for (int k = 1; k < NWORDS; k++) words[k] = '0;
      send_range(0, NWORDS - 1);
      tick();
      chk("one_error", 64'(error), 64'(1));
      chk("one_busy", 64'(busy), 64'(0));
      repeat (4) tick();

      // Reset after word 17 with a word presented in the reset cycle, then a full new load
      for (int k = 0; k < NWORDS; k++) words[k] = 32'hC5C5_0000 + 32'(2 * k + 1);
      send_range(0, 17);
      rst = 1'b1; in_valid = 1'b1; in_word = 32'hDEAD_BEEF;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_mid_params_valid", 64'(params_valid), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_error", 64'(error), 64'(0));
      chk("rst_mid_n0p_out", 64'(n0p_out), 64'(0));
      chk_wide("rst_mid_t_out", t_out, '0);
      chk_wide("rst_mid_eng_n", eng_n, '0);
      for (int k = 0; k < NWORDS; k++) words[k] = 32'h5A5A_0001 + 32'(k << 4);
      c_n = build_n();
      eng_n0p = 32'hC3C3_0003; eng_r = {NWORDS{32'h0000_00C2}}; eng_t = {NWORDS{32'h0000_00C3}};
      mode = MODE_DELAY;
      send_range(0, NWORDS - 1);
      p = last_cyc;
      start_q.push_back('{p + 1, c_n});
      res_q.push_back('{p + 12, 32'hC3C3_0003, {NWORDS{32'h0000_00C2}}, {NWORDS{32'h0000_00C3}}, c_n});
      wait_pv();

      // Engine never answers
      for (int k = 0; k < NWORDS; k++) words[k] = 32'hD00D_0001 + 32'(k * 4);
      mode = MODE_NEVER;
      send_range(0, NWORDS - 1);
      p = last_cyc;
      start_q.push_back('{p + 1, build_n()});
`ifdef KEY_PARAM_TIMEOUT_EN
      repeat (65) tick();
      chk("to_busy_last_wait_cycle", 64'(busy), 64'(1));
      chk("to_error_before_limit", 64'(error), 64'(0));
      tick();
      chk("to_error", 64'(error), 64'(1));
      chk("to_busy_idle", 64'(busy), 64'(0));
      chk("to_in_ready_idle", 64'(in_ready), 64'(1));
      chk("to_params_valid", 64'(params_valid), 64'(0));
`else
      repeat (66) tick();
      chk("nodone_busy_early", 64'(busy), 64'(1));
      repeat (200) tick();
      chk("nodone_busy_late", 64'(busy), 64'(1));
      chk("nodone_error", 64'(error), 64'(0));
      chk("nodone_params_valid", 64'(params_valid), 64'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("nodone_busy_after_rst", 64'(busy), 64'(0));
`endif
      repeat (3) tick();
      chk("start_queue_drained", 64'(start_q.size()), 64'(0));
      chk("result_queue_drained", 64'(res_q.size()), 64'(0));
      chk("total_start_pulses", 64'(start_count), 64'(4));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_param_loader.md
Name: key_param_loader

Overview:
- Host-side initiator for the secondary-input precompute engine, which computes n0', r and t from modulus n.
- Accepts the 1024-bit modulus n as 32-bit words and assembles it.
- Issues the engine start pulse, waits for the engine's done, then latches n0p/r/t into stable output registers for the Montgomery exponentiation datapath.

Parameters:
- WW, 32, host word width in bits
- NWORDS, 32, words per modulus (NBITS = WW*NWORDS = 1024)
- DONE_GUARD, 2, cycles after eng_start during which eng_done is ignored (the engine's done is level/sticky)
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with the optional feature)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  host word valid
- in_ready  out  1  loader can accept a word
- in_word  in  WW  modulus word, least-significant word first
- eng_start  out  1  one-cycle start pulse to the precompute engine
- eng_n  out  NBITS  assembled modulus; held stable from the START state until the next load begins
- eng_done  in  1  engine done (level)
- eng_n0p  in  32  engine n0' result
- eng_r  in  NBITS  engine r result
- eng_t  in  NBITS  engine t result
- params_valid  out  1  n0p_out/r_out/t_out/n_out hold a consistent set
- n0p_out  out  32  latched n0'
- r_out  out  NBITS  latched r
- t_out  out  NBITS  latched t
- n_out  out  NBITS  modulus matching the latched set
- busy  out  1  high in LOAD, START, WAIT
- error  out  1  sticky error flag; cleared by rst or by the first word of a new load

Behaviour:
- Reset values:
  - every output and register is 0
  - state = IDLE
  - word counter = 0
- Transfer rule: a word transfers when in_valid && in_ready.
- Word k (k = 0..NWORDS-1) is written to eng_n[WW*k +: WW].
- States:
  - IDLE: in_ready=1. The first transfer writes word 0, sets cnt=1, clears error, and goes to LOAD.
  - LOAD: in_ready=1. Each transfer writes word cnt and increments cnt. On the transfer of word NWORDS-1, go to CHECK. Gaps (in_valid=0) are allowed indefinitely.
  - CHECK (1 cycle, in_ready=0):
    - If eng_n[0]==0 (even modulus) or eng_n==1: set error=1 and go to IDLE; no start is issued.
    - Otherwise go to START.
  - START (1 cycle): eng_start=1, guard counter=DONE_GUARD, go to WAIT.
  - WAIT:
    - in_ready=0.
    - Decrement the guard counter to 0; eng_done is ignored while guard>0.
    - The first cycle with guard==0 && eng_done==1 latches eng_n0p/eng_r/eng_t into n0p_out/r_out/t_out and eng_n into n_out, then goes to HOLD.
  - HOLD:
    - params_valid=1 one cycle after the latch cycle; in_ready=1.
    - A transfer here starts a new load: params_valid drops to 0 in the same edge, error clears, word 0 is written, go to LOAD.
    - eng_done has no effect in HOLD.
- Latency: start pulse 2 cycles after the last word transfer; params_valid 1 cycle after the qualified done.
- eng_start is asserted only in START and never twice per load.
- Outputs n0p_out/r_out/t_out/n_out change only on the latch edge or on rst.
- rst mid-operation, in any state: the next cycle is IDLE with all outputs 0. A pulse already sent to the engine is not cancelled, and a later eng_done is ignored (IDLE).
- A partial load is never committed; only rst aborts LOAD.
- Simultaneous rst and transfer: rst wins and the word is dropped.

Optional Feature:
- Macro: KEY_PARAM_TIMEOUT_EN.
- When defined:
  - A 13-bit watchdog counts cycles in WAIT.
  - Reaching TIMEOUT_CYCLES without a qualified done sets error=1 and goes to IDLE with params_valid=0; the previous latched set is not restored.
- When undefined:
  - No counter exists.
  - WAIT waits indefinitely.
  - error is set only by the CHECK failure.

Test Plan:
- Load 32 words 0x00000001, 0x11111111, ..., with word 31=0x80000000, no gaps. Engine model asserts done 10 cycles after start.
  -> eng_start pulses exactly once, 2 cycles after the last word.
  -> eng_n matches the words.
  -> params_valid=1 with n0p_out/r_out/t_out equal to the model values.
- Model holds eng_done=1 continuously (sticky from the previous run) with DONE_GUARD=2.
  -> No latch before START+3; the latch happens at the first cycle with guard==0.
- Word 0=0x00000002 (even modulus).
  -> error=1, eng_start never asserted, state IDLE, params_valid=0.
- Assert rst after word 17, then load a full new modulus.
  -> Outputs 0 after reset.
  -> The second load completes with only new words in eng_n; exactly one start pulse follows the second load.
- In HOLD with a valid set, send a new word 0.
  -> params_valid falls on the same edge; old n0p_out/r_out/t_out hold until the new latch.
- With KEY_PARAM_TIMEOUT_EN and TIMEOUT_CYCLES=64, the model never asserts done.
  -> error=1 and state IDLE 64 cycles after entering WAIT.
  -> Without the macro, busy stays 1 indefinitely.
